// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
//
// Run-time program loader for the CPU instruction memory. A host (typically a
// UART receiver) streams a big-endian 16-bit word count followed by that many
// big-endian 32-bit instruction words. Each complete word is written to the
// next consecutive instruction-memory word address. The CPU is held in reset
// from power-up and during every load, and released only once a load
// completes successfully.
//
// Stream format:   LEN_HI LEN_LO { B3 B2 B1 B0 } x LEN  [CHK]
//   CHK is present only when LOADER_CHECKSUM_EN is defined. It must equal the
//   XOR of all payload bytes (the length bytes are excluded).
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   undefined : no CHECK state, no XOR register; the last word ends the load.
//   defined   : one trailing check byte is accepted; mismatch ends in ERROR.
//
// Parameters:
//   INSTR_MEM_SIZE  number of 32-bit words in instruction memory
//   ADDR_WIDTH      word-address width, 2**ADDR_WIDTH >= INSTR_MEM_SIZE
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   single-cycle pulse, begins a load (IDLE/DONE/ERROR only)
//   in_data     in   stream byte
//   in_valid    in   in_data is valid
//   in_ready    out  loader accepts a byte (transfer on in_valid && in_ready)
//   imem_we     out  instruction memory write enable, one pulse per word
//   imem_addr   out  word address of the write (held between writes)
//   imem_wdata  out  word to write (held between writes)
//   cpu_reset   out  active-high CPU reset, low only after a successful load
//   busy        out  load in progress
//   done        out  last load completed successfully (sticky)
//   error       out  last load failed (sticky)
// ----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int unsigned INSTR_MEM_SIZE = 32,
    parameter int unsigned ADDR_WIDTH     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // One extra bit so the word counter can represent INSTR_MEM_SIZE itself.
    localparam int unsigned CntW    = ADDR_WIDTH + 1;
    localparam logic [15:0] MemSize = 16'(INSTR_MEM_SIZE);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLenHi = 3'd1,
        StLenLo = 3'd2,
        StData  = 3'd3,
        StDone  = 3'd4,
        StError = 3'd5,
        StCheck = 3'd6
    } state_e;

    // Where the load goes once the payload has been fully received.
    localparam state_e StPayloadEnd = StCheck;
`else
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLenHi = 3'd1,
        StLenLo = 3'd2,
        StData  = 3'd3,
        StDone  = 3'd4,
        StError = 3'd5
    } state_e;

    localparam state_e StPayloadEnd = StDone;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q,    state_d;
    logic [15:0]           length_q,   length_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [CntW-1:0]       word_cnt_q, word_cnt_d;
    // Only the three leading bytes of a word need storing; the fourth byte
    // goes straight into the write data register on its handshake.
    logic [23:0]           asm_q,      asm_d;
    logic                  we_q,       we_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [31:0]           wdata_q,    wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            xor_q,      xor_d;
`endif

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    logic        xfer;
    logic [15:0] len_new;
    logic        last_word;

    assign xfer    = in_valid && in_ready;
    assign len_new = {length_q[15:8], in_data};
    // word_cnt_q is the index of the word being assembled.
    assign last_word = ((16'(word_cnt_q) + 16'd1) == length_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StLenHi;
                    length_d   = '0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    asm_d      = '0;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end
            end

            StLenHi: begin
                if (xfer) begin
                    length_d[15:8] = in_data;
                    state_d        = StLenLo;
                end
            end

            StLenLo: begin
                if (xfer) begin
                    length_d = len_new;
                    if (len_new == 16'd0) begin
                        state_d = StPayloadEnd;
                    end else if (len_new > MemSize) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end

            StData: begin
                if (xfer) begin
                    asm_d      = {asm_q[15:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d      = xor_q ^ in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Registered write: the pulse appears next cycle, which
                        // leaves the input free to take a byte every cycle.
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                        wdata_d    = {asm_q, in_data};
                        word_cnt_d = word_cnt_q + CntW'(1);
                        if (last_word) begin
                            state_d = StPayloadEnd;
                        end
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (xfer) begin
                    state_d = (in_data == xor_q) ? StDone : StError;
                end
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            length_q   <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: status is a pure function of the state, so done, busy and
    // cpu_reset all change on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        unique case (state_q)
            StLenHi, StLenLo, StData: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            StDone: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            StError: begin
                error = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Directed bench for instr_mem_loader. Expected instruction-memory writes are
// queued when a load is built and popped by a monitor on every imem_we pulse.
// Status outputs are checked at falling edges; inputs change 1 time unit after
// rising edges. Build with +define+LOADER_CHECKSUM_EN to exercise the check
// byte; every load then carries a correct trailing check byte.
// ----------------------------------------------------------------------------
module tb_instr_mem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    instr_mem_loader #(
        .INSTR_MEM_SIZE(32),
        .ADDR_WIDTH    (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stream_q[$];
    logic [7:0] pay_xor;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every imem_we pulse must match the head of the queue.
    always @(negedge clock) begin : monitor
        wr_t e;
        if (imem_we !== 1'b0) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=%h@%0d expected=none",
                       imem_wdata, imem_addr);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check32("write_addr", 32'(imem_addr), 32'(e.addr));
                check32("write_data", imem_wdata, e.data);
            end
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check1({tag, "_in_ready"}, in_ready, 1'b0);
        check1({tag, "_imem_we"}, imem_we, 1'b0);
        check32({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check32({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_error"}, error, 1'b0);
        check1({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    endtask

    // Starts at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got      = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (in_ready === 1'b1) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL handshake_timeout observed=no_ready expected=ready byte=%h", b);
        end
        if (got) sync();
        in_valid = 1'b0;
        in_data  = 8'hFF;
    endtask

    task automatic run_stream(input int gap);
        for (int i = 0; i < stream_q.size(); i++) begin
            send_byte(stream_q[i]);
            if (gap > 0 && i < stream_q.size() - 1) begin
                repeat (gap) begin
                    @(negedge clock);
                    check1("gap_in_ready", in_ready, 1'b1);
                end
                sync();
            end
        end
    endtask

    task automatic new_load();
        stream_q.delete();
        pay_xor = 8'h00;
    endtask

    task automatic put_len(input logic [15:0] n);
        stream_q.push_back(n[15:8]);
        stream_q.push_back(n[7:0]);
    endtask

    task automatic put_word(input logic [4:0] addr, input logic [31:0] w, input bit expect_wr);
        logic [7:0] b;
        for (int k = 3; k >= 0; k--) begin
            b = w[8*k +: 8];
            stream_q.push_back(b);
            pay_xor = pay_xor ^ b;
        end
        if (expect_wr) exp_q.push_back('{addr: addr, data: w});
    endtask

    task automatic add_check();
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(pay_xor);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        sync();
        start = 1'b0;
    endtask

    task automatic check_started(input string tag);
        @(negedge clock);
        check1({tag, "_busy"}, busy, 1'b1);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_error"}, error, 1'b0);
        check1({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        check1({tag, "_in_ready"}, in_ready, 1'b1);
        sync();
    endtask

    task automatic check_done(input string tag);
        @(negedge clock);
        check1({tag, "_done"}, done, 1'b1);
        check1({tag, "_cpu_reset"}, cpu_reset, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_in_ready"}, in_ready, 1'b0);
        sync();
    endtask

    task automatic check_drained(input string tag);
        repeat (3) @(negedge clock);
        check32({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        sync();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        pay_xor  = 8'h00;

        // Reset values.
        #3;
        check_reset_vals("por");
        @(negedge clock);
        check_reset_vals("por_neg");
        sync();
        reset = 1'b0;
        sync();

        // Reset mid-DATA after 5 bytes, then a clean one-word load.
        pulse_start();
        check_started("t1_start");
        new_load();
        stream_q = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE};
        run_stream(0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midload_rst");
        @(negedge clock);
        check_reset_vals("midload_rst_neg");
        sync();
        reset = 1'b0;
        sync();
        pulse_start();
        check_started("t1_restart");
        new_load();
        put_len(16'd1);
        put_word(5'd0, 32'hDEADBEEF, 1'b1);
        add_check();
        run_stream(0);
        check_done("t1");
        check_drained("t1");

        // Two words back to back; restart from DONE reasserts cpu_reset.
        pulse_start();
        check_started("t2_restart");
        new_load();
        put_len(16'd2);
        put_word(5'd0, 32'h20080005, 1'b1);
        put_word(5'd1, 32'h20090007, 1'b1);
        add_check();
        run_stream(0);
        check_done("t2");
        @(negedge clock);
        check1("t2_done_sticky", done, 1'b1);
        check1("t2_cpu_reset_low", cpu_reset, 1'b0);
        check1("t2_we_single", imem_we, 1'b0);
        check32("t2_addr_held", 32'(imem_addr), 32'd1);
        check32("t2_wdata_held", imem_wdata, 32'h20090007);
        sync();
        check_drained("t2");

        // Same stream with 3-cycle idle gaps between bytes.
        pulse_start();
        check_started("t3");
        new_load();
        put_len(16'd2);
        put_word(5'd0, 32'h20080005, 1'b1);
        put_word(5'd1, 32'h20090007, 1'b1);
        add_check();
        run_stream(3);
        check_done("t3");
        check_drained("t3");

        // Oversize length -> ERROR; offered bytes are not taken.
        pulse_start();
        check_started("t4");
        new_load();
        put_len(16'd33);
        run_stream(0);
        @(negedge clock);
        check1("t4_error", error, 1'b1);
        check1("t4_in_ready", in_ready, 1'b0);
        check1("t4_cpu_reset", cpu_reset, 1'b1);
        check1("t4_busy", busy, 1'b0);
        check1("t4_done", done, 1'b0);
        sync();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) begin
            @(negedge clock);
            check1("t4_err_in_ready", in_ready, 1'b0);
            check1("t4_err_sticky", error, 1'b1);
        end
        sync();
        in_valid = 1'b0;
        check_drained("t4");

        // Zero length -> DONE with no writes; start from ERROR clears error.
        pulse_start();
        check_started("t5");
        new_load();
        put_len(16'd0);
        add_check();
        run_stream(0);
        check_done("t5");
        check_drained("t5");

        // start while busy is ignored.
        pulse_start();
        check_started("t6");
        new_load();
        put_len(16'd1);
        put_word(5'd0, 32'h12345678, 1'b1);
        add_check();
        begin
            logic [7:0] tail[$];
            tail = stream_q[4:$];
            stream_q = stream_q[0:3];
            run_stream(0);
            pulse_start();
            @(negedge clock);
            check1("t6_busy_kept", busy, 1'b1);
            check1("t6_ready_kept", in_ready, 1'b1);
            sync();
            stream_q = tail;
            run_stream(0);
        end
        check_done("t6");
        check_drained("t6");

        // Full memory: 32 words, addresses 0..31, no wrap.
        pulse_start();
        check_started("t7");
        new_load();
        put_len(16'd32);
        for (int i = 0; i < 32; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            put_word(5'(i), {8'hA5, iv, ~iv, 8'h3C}, 1'b1);
        end
        add_check();
        run_stream(0);
        check_done("t7");
        @(negedge clock);
        check32("t7_last_addr", 32'(imem_addr), 32'd31);
        sync();
        check_drained("t7");

`ifdef LOADER_CHECKSUM_EN
        // Good check byte.
        pulse_start();
        check_started("t8");
        new_load();
        put_len(16'd1);
        put_word(5'd0, 32'h11223344, 1'b1);
        stream_q.push_back(8'h44);
        run_stream(0);
        check_done("t8");
        check_drained("t8");

        // Bad check byte: word stays written, CPU stays in reset.
        pulse_start();
        check_started("t9");
        new_load();
        put_len(16'd1);
        put_word(5'd0, 32'h11223344, 1'b1);
        stream_q.push_back(8'h45);
        run_stream(0);
        @(negedge clock);
        check1("t9_error", error, 1'b1);
        check1("t9_cpu_reset", cpu_reset, 1'b1);
        check1("t9_done", done, 1'b0);
        sync();
        check_drained("t9");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
